// File: rtl/pq_pkg.sv
// pq_pkg: shared types and helpers for the hardware priority queue family.
//   kv_t      : packed <key,value> entry (key in the upper bits)
//   KEYINF    : largest key; a legal user key that sorts last
//   KV_EMPTY  : content of every unoccupied slot
//   pq_op_t   : per-cycle operation, decoded once from enq/deq/empty/full
//   kv_le     : key compare a.key <= b.key (unsigned)
//   pq_decode : enq/deq/empty/full -> pq_op_t
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam logic [KEY_WIDTH-1:0] KEYINF   = '1;
    localparam kv_t                  KV_EMPTY = '{key: KEYINF, val: '0};

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_INSERT,
        OP_REMOVE,
        OP_REPLACE
    } pq_op_t;

    function automatic logic kv_le(input kv_t a, input kv_t b);
        return a.key <= b.key;
    endfunction

    // Dropped enqueues (full) and ignored dequeues (empty) collapse to IDLE.
    // enq+deq on an empty queue has no head to remove, so it is a plain insert.
    function automatic pq_op_t pq_decode(input logic enq, input logic deq,
                                         input logic empty, input logic full);
        if (enq && deq)
            return empty ? OP_INSERT : OP_REPLACE;
        else if (enq)
            return full ? OP_IDLE : OP_INSERT;
        else if (deq)
            return empty ? OP_IDLE : OP_REMOVE;
        else
            return OP_IDLE;
    endfunction

endpackage

// File: rtl/pq_sr_cell.sv
// pq_sr_cell: one slot of the sorted shift-register priority queue.
//   clk, rst   : clock, synchronous active-high reset (slot -> KV_EMPTY)
//   op         : operation decoded by the top for this cycle
//   kv_left    : value of slot i-1 (KV_EMPTY for slot 0)
//   kv_right   : value of slot i+1 (KV_EMPTY for the last slot)
//   kv_in      : entry being inserted
//   valid      : this slot currently holds a live entry
//   le_left    : compare flag of slot i-1 (1 for slot 0)
//   le_right   : compare flag of slot i+1 (0 for the last slot)
//   le         : this slot is valid and its key <= kv_in.key
//   kv_q       : registered slot contents
module pq_sr_cell
    import pq_pkg::*;
#(
    parameter bit IS_HEAD = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  pq_op_t op,
    input  kv_t    kv_left,
    input  kv_t    kv_right,
    input  kv_t    kv_in,
    input  logic   valid,
    input  logic   le_left,
    input  logic   le_right,
    output logic   le,
    output kv_t    kv_q
);

    kv_t kv_d;

    // The le flags form a run of ones over the valid prefix, so the first
    // slot with le=0 is the insert point; equal keys stay ahead of kv_in.
    assign le = valid && kv_le(kv_q, kv_in);

    always_comb begin
        kv_d = kv_q;
        unique case (op)
            OP_INSERT: begin
                if (le)
                    kv_d = kv_q;
                else if (le_left)
                    kv_d = kv_in;
                else
                    kv_d = kv_left;
            end
            OP_REMOVE: kv_d = kv_right;
            // Head leaves while kv_in lands: entries below the insert point
            // shift down one slot, entries above it stay where they are.
            OP_REPLACE: begin
                if (le_right)
                    kv_d = kv_right;
                else if (le || IS_HEAD)
                    kv_d = kv_in;
                else
                    kv_d = kv_q;
            end
            default: kv_d = kv_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            kv_q <= KV_EMPTY;
        else
            kv_q <= kv_d;
    end

endmodule

// File: rtl/pq_shiftreg.sv
// pq_shiftreg: sorted shift-register hardware priority queue.
//   clk, rst : clock, synchronous active-high reset
//   enq      : insert kv_in this cycle
//   deq      : remove the head entry this cycle
//   kv_in    : entry to insert
//   kv_out   : registered head (slot 0), KV_EMPTY when empty
//   empty    : count == 0
//   full     : count == CAPACITY
//   count    : number of valid entries
//   ovf      : one-cycle pulse, enqueue dropped on a full queue
//   udf      : one-cycle pulse, dequeue ignored on an empty queue
module pq_shiftreg
    import pq_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  kv_t              kv_in,
    output kv_t              kv_out,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             udf
);

    pq_op_t op;

    // Padded neighbour chains: index i+1 holds slot i, the two ends are the
    // constant boundary values seen by the first and last slot.
    kv_t            nb     [CAPACITY+2];
    logic [CAPACITY+1:0] le_ext;
    logic [CAPACITY-1:0] valid;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(CAPACITY));
    assign op    = pq_decode(enq, deq, empty, full);

    assign nb[0]              = KV_EMPTY;
    assign nb[CAPACITY+1]     = KV_EMPTY;
    assign le_ext[0]          = 1'b1;
    assign le_ext[CAPACITY+1] = 1'b0;

    for (genvar i = 0; i < CAPACITY; i++) begin : g_cell
        assign valid[i] = (count > CNT_W'(i));

        pq_sr_cell #(
            .IS_HEAD (i == 0)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .op       (op),
            .kv_left  (nb[i]),
            .kv_right (nb[i+2]),
            .kv_in    (kv_in),
            .valid    (valid[i]),
            .le_left  (le_ext[i]),
            .le_right (le_ext[i+2]),
            .le       (le_ext[i+1]),
            .kv_q     (nb[i+1])
        );
    end

    assign kv_out = nb[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            unique case (op)
                OP_INSERT: count <= count + CNT_W'(1);
                OP_REMOVE: count <= count - CNT_W'(1);
                default:   count <= count;
            endcase
            ovf <= enq && !deq && full;
            udf <= deq && empty;
        end
    end

endmodule

// File: tb/tb_pq_shiftreg.sv
module tb_pq_shiftreg;
    import pq_pkg::*;

    localparam int CAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    kv_t        kv_in = KV_EMPTY;
    kv_t        kv_out;
    logic       empty, full, ovf, udf;
    logic [4:0] count;

    pq_shiftreg #(.CAPACITY(CAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .enq    (enq),
        .deq    (deq),
        .kv_in  (kv_in),
        .kv_out (kv_out),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] k;
        logic [7:0] v;
        int         cnt;
        bit         ovf;
        bit         udf;
    } exp_t;

    exp_t exp_q[$];
    kv_t  mq[$];
    bit   m_ovf, m_udf;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural reference: an ordered list with FIFO order among equal keys.
    task automatic model_step(input bit e, input bit d, input bit r, input kv_t kin);
        int p;
        if (r) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            m_ovf = e && !d && (mq.size() == CAP);
            m_udf = d && (mq.size() == 0);
            if (e && d && mq.size() > 0) begin
                void'(mq.pop_front());
                p = 0;
                while (p < mq.size() && mq[p].key <= kin.key) p++;
                mq.insert(p, kin);
            end else if (e && mq.size() < CAP) begin
                p = 0;
                while (p < mq.size() && mq[p].key <= kin.key) p++;
                mq.insert(p, kin);
            end else if (d && !e && mq.size() > 0) begin
                void'(mq.pop_front());
            end
        end
    endtask

    task automatic drive(input bit e, input bit d, input bit r, input logic [7:0] k, input logic [7:0] v);
        @(negedge clk);
        enq   = e;
        deq   = d;
        rst   = r;
        kv_in = '{key: k, val: v};
        model_step(e, d, r, kv_in);
    endtask

    // Directed step: expectation is the hand-computed value.
    task automatic op_h(input bit e, input bit d, input bit r, input logic [7:0] k, input logic [7:0] v,
                        input logic [7:0] ek, input logic [7:0] ev, input int ec, input bit eo, input bit eu);
        exp_t x;
        drive(e, d, r, k, v);
        x.k = ek; x.v = ev; x.cnt = ec; x.ovf = eo; x.udf = eu;
        exp_q.push_back(x);
    endtask

    // Random step: expectation comes from the reference model.
    task automatic op_m(input bit e, input bit d, input bit r, input logic [7:0] k, input logic [7:0] v);
        exp_t x;
        drive(e, d, r, k, v);
        x.k   = (mq.size() > 0) ? mq[0].key : KEYINF;
        x.v   = (mq.size() > 0) ? mq[0].val : 8'h00;
        x.cnt = mq.size();
        x.ovf = m_ovf;
        x.udf = m_udf;
        exp_q.push_back(x);
    endtask

    // Monitor: every edge that applied a queued operation gets one check.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                #1;
                x = exp_q.pop_front();
                chk("kv_out.key", int'(kv_out.key), int'(x.k));
                chk("kv_out.val", int'(kv_out.val), int'(x.v));
                chk("count",      int'(count),      x.cnt);
                chk("empty",      int'(empty),      int'(x.cnt == 0));
                chk("full",       int'(full),       int'(x.cnt == CAP));
                chk("ovf",        int'(ovf),        int'(x.ovf));
                chk("udf",        int'(udf),        int'(x.udf));
            end
        end
    end

    initial begin
        bit e, d, r;
        int bias;
        logic [7:0] k;

        // Reset, idle, dequeue on empty
        op_h(0, 0, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0);
        op_h(0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0);
        op_h(0, 1, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 1);
        op_h(0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // Ordering and FIFO among equal keys
        op_h(1, 0, 0, 8'd5, 8'h0A, 8'd5, 8'h0A, 1, 0, 0);
        op_h(1, 0, 0, 8'd2, 8'h0B, 8'd2, 8'h0B, 2, 0, 0);
        op_h(1, 0, 0, 8'd9, 8'h0C, 8'd2, 8'h0B, 3, 0, 0);
        op_h(1, 0, 0, 8'd2, 8'h0D, 8'd2, 8'h0B, 4, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'd2, 8'h0D, 3, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'd5, 8'h0A, 2, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'd9, 8'h0C, 1, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // Fill with descending keys, overflow, replace while full
        for (int i = 16; i >= 1; i--)
            op_h(1, 0, 0, 8'(i), 8'(i), 8'(i), 8'(i), 17 - i, 0, 0);
        op_h(1, 0, 0, 8'd0, 8'h00, 8'd1, 8'd1, 16, 1, 0);
        op_h(0, 0, 0, 8'd0, 8'h00, 8'd1, 8'd1, 16, 0, 0);
        op_h(1, 1, 0, 8'd0, 8'h00, 8'd0, 8'd0, 16, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'd2, 8'd2, 15, 0, 0);
        op_h(0, 0, 1, 8'd0, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // Replace on a single entry
        op_h(1, 0, 0, 8'd7, 8'h58, 8'd7, 8'h58, 1, 0, 0);
        op_h(1, 1, 0, 8'd3, 8'h59, 8'd3, 8'h59, 1, 0, 0);
        op_h(1, 1, 0, 8'd8, 8'h5A, 8'd8, 8'h5A, 1, 0, 0);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // KEYINF is a real key, distinct from an empty slot
        op_h(1, 0, 0, 8'd4,  8'h50, 8'd4,  8'h50, 1, 0, 0);
        op_h(1, 0, 0, 8'hFF, 8'h56, 8'd4,  8'h50, 2, 0, 0);
        op_h(0, 1, 0, 8'd0,  8'h00, 8'hFF, 8'h56, 1, 0, 0);
        op_h(0, 1, 0, 8'd0,  8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // enq+deq on empty acts as insert and flags underflow
        op_h(1, 1, 0, 8'd6, 8'h01, 8'd6, 8'h01, 1, 0, 1);
        op_h(0, 1, 0, 8'd0, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

        // Reset wins over a simultaneous enqueue
        for (int i = 0; i < 5; i++)
            op_h(1, 0, 0, 8'(10 + i), 8'(i), 8'd10, 8'd0, i + 1, 0, 0);
        op_h(1, 0, 1, 8'd3, 8'h03, 8'hFF, 8'h00, 0, 0, 0);

        // Random traffic against the reference model, alternating fill/drain bias
        for (int c = 0; c < 10000; c++) begin
            bias = ((c / 500) % 2 == 0) ? 7 : 3;
            e = ($urandom_range(0, 9) < bias);
            d = ($urandom_range(0, 9) < 10 - bias);
            r = ($urandom_range(0, 499) == 0);
            k = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            op_m(e, d, r, k, 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_shiftreg.md
Name: pq_shiftreg

Overview:
- Sorted shift-register hardware priority queue (HWPQ) built on the team's shared `kv_t` <key,value> type and the standard HWPQ enq/deq interface.
- Holds up to CAPACITY entries in ascending key order. Slot 0 is always the minimum key and is presented registered on `kv_out`.
- Acts as the small, fast storage stage that consumes `kv_t` traffic from producers and serves min-key dequeues to downstream consumers.
- Baseline implementation against which the other HWPQ variants in the study are compared.

Parameters:
- CAPACITY, 16, number of storage slots (≥2).
- CNT_W, $clog2(CAPACITY+1), width of `count`. Derived; do not override.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enq  in  1  insert `kv_in` this cycle.
- deq  in  1  remove the head entry this cycle.
- kv_in  in  kv_t  entry to insert.
- kv_out  out  kv_t  current head (slot 0); equals KV_EMPTY when empty.
- empty  out  1  count == 0.
- full  out  1  count == CAPACITY.
- count  out  CNT_W  number of valid entries.
- ovf  out  1  one-cycle pulse: enq dropped because the queue was full and deq was not asserted.
- udf  out  1  one-cycle pulse: deq ignored because the queue was empty.

Behaviour:
- Reset (rst=1 at clock edge): all slots = KV_EMPTY, count=0, empty=1, full=0, ovf=0, udf=0, so kv_out=KV_EMPTY. rst has priority over enq/deq in the same cycle. Mid-operation reset discards all contents.
- Validity is defined by count: slots [0..count-1] are valid. Invalid slots hold KV_EMPTY. Key KEYINF is a legal user key; it is ordered last and is never used as a validity marker.
- Every operation completes in one cycle. Results are visible on `kv_out`, `count`, `empty` and `full` the cycle after the edge. `kv_out` is a direct register output (no combinational path from inputs).
- Ordering: ascending key. Equal keys are served FIFO: a new entry is placed after all existing entries with key ≤ kv_in.key.
- Insert-position rule: p = number of valid slots whose key ≤ kv_in.key, computed with per-slot unsigned compares on the pre-edge contents.
- Cases, evaluated on pre-edge state:
  - IDLE (no enq, no deq): hold.
  - INSERT (enq, !deq, !full): slot[i] = old[i] for i<p; slot[p] = kv_in; slot[i] = old[i-1] for i>p. count+1.
  - INSERT while full (enq, !deq, full): no state change; ovf=1 next cycle.
  - REMOVE (deq, !enq, !empty): slot[i] = old[i+1]; slot[CAPACITY-1] = KV_EMPTY. count-1.
  - REMOVE while empty (deq, !enq, empty): no change; udf=1 next cycle.
  - REPLACE (enq, deq, !empty): head is removed and kv_in inserted in the same edge. p' = number of old[1..count-1] with key ≤ kv_in.key. slot[i] = old[i+1] for i<p'; slot[p'] = kv_in; slot[i] = old[i] for i>p'. count unchanged. Legal when full; no ovf.
  - enq+deq while empty: treated as INSERT (count 0→1), udf=1. No bypass of kv_in to any output in that cycle.
- ovf and udf are registered and deasserted in every cycle where the condition does not occur.
- count never exceeds CAPACITY and never underflows; there is no wrap-around.

Decomposition:
- pq_pkg: `kv_t`, KEY_WIDTH, VAL_WIDTH, KEYINF, KV_EMPTY.
  - Add `pq_op_t` enum {OP_IDLE, OP_INSERT, OP_REMOVE, OP_REPLACE}, decoded once from enq/deq/empty/full.
  - Add function `kv_le(a,b)` (a.key ≤ b.key).
- Sub-module `pq_sr_cell`: one slot register.
  - Inputs: op, own/left/right neighbour values, kv_in, valid, and the compare result of its left neighbour.
  - Computes its own `le` flag and next value.
  - Instantiated CAPACITY times in a generate loop. Slot 0 left neighbour and slot CAPACITY-1 right neighbour are tied to KV_EMPTY.

Test Plan:
- Reset then idle → kv_out=KV_EMPTY, empty=1, count=0; deq → udf pulse 1 cycle, state unchanged.
- Enq keys 5,2,9,2 (values A,B,C,D) → kv_out key 2 value B, count=4. Successive deqs return (2,B),(2,D),(5,A),(9,C), then empty=1.
- Fill CAPACITY=16 with keys 16..1 → full=1, kv_out key 1. Enq key 0 alone → ovf=1, contents unchanged. Enq key 0 with deq → kv_out key 0, count=16, full=1.
- Replace on a single entry: queue {(7,X)}, enq (3,Y)+deq → kv_out (3,Y), count=1. Then enq (8,Z)+deq → kv_out (8,Z).
- Enq KEYINF (0xFF,V) into {(4,P)} → order (4,P),(0xFF,V), count=2. Deq twice → second output is (0xFF,V), after which empty=1.
- Assert rst in the same cycle as enq with count=5 → next cycle count=0, kv_out=KV_EMPTY, ovf=udf=0. Random enq/deq scoreboard against a reference model for 10k cycles with no mismatch.
